// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants, state encoding and helpers for the FIFO read-side drain controller.
package fifo_rd_stream_pkg;

   localparam int unsigned DEF_DATA_W  = 32;
   localparam int unsigned DEF_PKT_LEN = 4;
   localparam int unsigned DEF_CNT_W   = 16;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_RUN   = 2'd1;
   localparam state_t ST_DRAIN = 2'd2;

   // Beat counter width; a single-word packet still needs a 1-bit register.
   function automatic int unsigned beat_width(input int unsigned pkt_len);
      return (pkt_len > 1) ? $clog2(pkt_len) : 1;
   endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry register buffer; head is always the oldest word. Push and pop may coincide
// at any occupancy, so a full buffer can stream at one word per cycle.
module stream_skid_buf
   import fifo_rd_stream_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic              i_rdclk,
   input  logic              i_aclr,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_push_data,
   input  logic              i_pop,
   output logic [1:0]        o_occ,
   output logic [DATA_W-1:0] o_head_data
);

   logic [1:0]        r_occ;
   logic [DATA_W-1:0] r_head;
   logic [DATA_W-1:0] r_tail;
   logic              w_pop;

   // Popping an empty buffer is meaningless; ignore it rather than underflow.
   assign w_pop = i_pop & (r_occ != 2'd0);

   // Occupancy and storage update for push, pop, or both.
   always_ff @(posedge i_rdclk or posedge i_aclr) begin
      if (i_aclr) begin
         r_occ  <= 2'd0;
         r_head <= '0;
         r_tail <= '0;
      end else begin
         case ({i_push, w_pop})
            2'b10: begin
               if (r_occ == 2'd0) begin
                  r_head <= i_push_data;
                  r_occ  <= 2'd1;
               end else if (r_occ == 2'd1) begin
                  r_tail <= i_push_data;
                  r_occ  <= 2'd2;
               end
            end
            2'b01: begin
               if (r_occ == 2'd2) begin
                  r_head <= r_tail;
               end
               r_occ <= r_occ - 2'd1;
            end
            2'b11: begin
               if (r_occ == 2'd1) begin
                  r_head <= i_push_data;
               end else begin
                  r_head <= r_tail;
                  r_tail <= i_push_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_occ       = r_occ;
   assign o_head_data = r_head;

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a non-showahead FIFO read port into a valid/ready stream with packet framing.
// rdreq looks at this cycle's pop so a full buffer still reads every cycle.
module fifo_rd_stream
   import fifo_rd_stream_pkg::*;
#(
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned PKT_LEN = DEF_PKT_LEN,
   parameter int unsigned CNT_W   = DEF_CNT_W
) (
   input  logic              i_rdclk,
   input  logic              i_aclr,
   input  logic              i_enable,
   input  logic              i_rdempty,
   output logic              o_rdreq,
   input  logic [DATA_W-1:0] i_q,
   output logic              o_m_valid,
   input  logic              i_m_ready,
   output logic [DATA_W-1:0] o_m_data,
   output logic              o_m_last,
   output logic [CNT_W-1:0]  o_pkt_count,
   output logic              o_busy
);

   localparam int unsigned       BEAT_W    = beat_width(PKT_LEN);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic               r_inflight;
   logic [BEAT_W-1:0]  r_beat;
   logic [CNT_W-1:0]   r_pkt_count;

   logic [1:0]         w_occ;
   logic [DATA_W-1:0]  w_head;
   logic               w_valid;
   logic               w_pop;
   logic               w_last;
   logic               w_rdreq;
   logic [2:0]         w_outstanding;

   assign w_valid = (w_occ != 2'd0);
   assign w_pop   = w_valid & i_m_ready;
   assign w_last  = w_valid & (r_beat == LAST_BEAT);

   // Words held or on their way once this cycle's pop is taken out; never exceeds 2.
   assign w_outstanding = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_rdreq       = (r_state == ST_RUN) & ~i_rdempty & (w_outstanding < 3'd2);

   // Next-state logic; re-enable during drain wins over going idle.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (i_enable) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (!i_enable) w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (i_enable) begin
               w_state_nxt = ST_RUN;
            end else if ((w_occ == 2'd0) && !r_inflight) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State register and in-flight read flag (q arrives the cycle after rdreq).
   always_ff @(posedge i_rdclk or posedge i_aclr) begin
      if (i_aclr) begin
         r_state    <= ST_IDLE;
         r_inflight <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_inflight <= w_rdreq;
      end
   end

   // Packet framing: beat survives enable drops, only a last-word pop closes a packet.
   always_ff @(posedge i_rdclk or posedge i_aclr) begin
      if (i_aclr) begin
         r_beat      <= '0;
         r_pkt_count <= '0;
      end else if (w_pop) begin
         if (w_last) begin
            r_beat      <= '0;
            r_pkt_count <= r_pkt_count + CNT_W'(1);
         end else begin
            r_beat <= r_beat + BEAT_W'(1);
         end
      end
   end

   stream_skid_buf #(
      .DATA_W (DATA_W)
   ) u_buf (
      .i_rdclk     (i_rdclk),
      .i_aclr      (i_aclr),
      .i_push      (r_inflight),
      .i_push_data (i_q),
      .i_pop       (w_pop),
      .o_occ       (w_occ),
      .o_head_data (w_head)
   );

   assign o_rdreq     = w_rdreq;
   assign o_m_valid   = w_valid;
   assign o_m_data    = w_head;
   assign o_m_last    = w_last;
   assign o_pkt_count = r_pkt_count;
   assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomized bench for fifo_rd_stream against a queue/counter model of the FIFO and stream.
// A second instance with PKT_LEN=1, CNT_W=2 shares all inputs to cover single-word packets.
module tb_fifo_rd_stream;

   localparam int unsigned DW = 32;
   localparam int unsigned PL = 4;

   logic          clk = 1'b0;
   logic          aclr;
   logic          enable;
   logic          rdempty;
   logic          m_ready;
   logic [DW-1:0] q;

   logic          rdreq, m_valid, m_last, busy;
   logic [DW-1:0] m_data;
   logic [15:0]   pkt_count;
   logic          rdreq1, m_valid1, m_last1, busy1;
   logic [DW-1:0] m_data1;
   logic [1:0]    pkt_count1;

   always #5 clk = ~clk;

   fifo_rd_stream #(
      .DATA_W  (DW),
      .PKT_LEN (PL),
      .CNT_W   (16)
   ) dut (
      .i_rdclk     (clk),
      .i_aclr      (aclr),
      .i_enable    (enable),
      .i_rdempty   (rdempty),
      .o_rdreq     (rdreq),
      .i_q         (q),
      .o_m_valid   (m_valid),
      .i_m_ready   (m_ready),
      .o_m_data    (m_data),
      .o_m_last    (m_last),
      .o_pkt_count (pkt_count),
      .o_busy      (busy)
   );

   fifo_rd_stream #(
      .DATA_W  (DW),
      .PKT_LEN (1),
      .CNT_W   (2)
   ) dut1 (
      .i_rdclk     (clk),
      .i_aclr      (aclr),
      .i_enable    (enable),
      .i_rdempty   (rdempty),
      .o_rdreq     (rdreq1),
      .i_q         (q),
      .o_m_valid   (m_valid1),
      .i_m_ready   (m_ready),
      .o_m_data    (m_data1),
      .o_m_last    (m_last1),
      .o_pkt_count (pkt_count1),
      .o_busy      (busy1)
   );

   int            n_vec = 0;
   int            n_err = 0;

   // Model: FIFO contents, words read in order, and running counts.
   logic [DW-1:0] fifo_m[$];
   logic [DW-1:0] exp_q[$];
   int            rd_cnt;   // words requested from the FIFO
   int            cap_cnt;  // words that have landed in the buffer
   int            acc_cnt;  // words accepted downstream
   int            mst;      // 0 idle, 1 run, 2 drain
   int            n_rdreq;
   logic          prev_stall;
   logic [DW-1:0] prev_data;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      fifo_m.delete();
      exp_q.delete();
      rd_cnt     = 0;
      cap_cnt    = 0;
      acc_cnt    = 0;
      mst        = 0;
      prev_stall = 1'b0;
      prev_data  = '0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_rdreq"}, rdreq, 0);
      chk({tag, "_m_valid"}, m_valid, 0);
      chk({tag, "_m_data"}, m_data, 0);
      chk({tag, "_m_last"}, m_last, 0);
      chk({tag, "_pkt_count"}, pkt_count, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_rdreq1"}, rdreq1, 0);
      chk({tag, "_m_valid1"}, m_valid1, 0);
      chk({tag, "_pkt_count1"}, pkt_count1, 0);
      chk({tag, "_busy1"}, busy1, 0);
   endtask

   task automatic push_words(input int n);
      for (int i = 0; i < n; i++) fifo_m.push_back($urandom());
   endtask

   // One clock: drive rdempty, check outputs before the edge, then advance the model.
   task automatic cycle();
      logic          exp_valid;
      logic          exp_rdreq;
      logic          pop;
      logic          got;
      logic          dut_rdreq;
      logic [DW-1:0] word;
      int            outst;
      int            held;
      @(negedge clk);
      rdempty = (fifo_m.size() == 0);
      #1;
      exp_valid = (cap_cnt > acc_cnt);
      pop       = exp_valid && m_ready;
      held      = rd_cnt - acc_cnt;
      outst     = held - (pop ? 1 : 0);
      exp_rdreq = (mst == 1) && !rdempty && (outst < 2);
      dut_rdreq = rdreq;
      chk("m_valid", m_valid, exp_valid);
      chk("rdreq", rdreq, exp_rdreq);
      chk("busy", busy, (mst != 0));
      chk("m_valid1", m_valid1, exp_valid);
      chk("rdreq1", rdreq1, exp_rdreq);
      chk("pkt_count", pkt_count, (acc_cnt / PL) % 65536);
      chk("pkt_count1", pkt_count1, acc_cnt % 4);
      if (exp_valid) begin
         chk("m_data", m_data, exp_q[0]);
         chk("m_last", m_last, ((acc_cnt % PL) == PL - 1));
         chk("m_data1", m_data1, exp_q[0]);
         chk("m_last1", m_last1, 1);
         if (prev_stall) chk("m_data_hold", m_data, prev_data);
      end else begin
         chk("m_last_idle", m_last, 0);
      end
      prev_stall = exp_valid && !m_ready;
      prev_data  = m_data;
      @(posedge clk);
      case (mst)
         0: if (enable) mst = 1;
         1: if (!enable) mst = 2;
         default: begin
            if (enable) mst = 1;
            else if (held == 0) mst = 0;
         end
      endcase
      if (pop) begin
         void'(exp_q.pop_front());
         acc_cnt++;
      end
      cap_cnt = rd_cnt;
      got     = 1'b0;
      word    = '0;
      if (dut_rdreq) begin
         n_rdreq++;
         if (fifo_m.size() != 0) begin
            word = fifo_m.pop_front();
            got  = 1'b1;
         end
         exp_q.push_back(word);
         rd_cnt++;
      end
      #1;
      q = got ? word : $urandom();
   endtask

   initial begin
      int target;
      int pushed;
      int k;
      logic found;

      aclr    = 1'b1;
      enable  = 1'b0;
      m_ready = 1'b0;
      q       = '0;
      rdempty = 1'b1;
      n_rdreq = 0;
      model_reset();
      #1;
      check_reset_outputs("reset");
      repeat (2) @(posedge clk);
      #1 aclr = 1'b0;

      // Four words, always ready: one full packet.
      for (int i = 1; i <= 4; i++) fifo_m.push_back(i);
      enable  = 1'b1;
      m_ready = 1'b1;
      repeat (10) cycle();
      chk("t1_words", acc_cnt, 4);
      chk("t1_pkt", pkt_count, 1);

      // Long stall: exactly two reads, then everything drains in order.
      m_ready = 1'b0;
      for (int i = 0; i < 8; i++) fifo_m.push_back(32'h100 + i);
      n_rdreq = 0;
      repeat (10) cycle();
      chk("t2_stall_rdreq", n_rdreq, 2);
      m_ready = 1'b1;
      repeat (14) cycle();
      chk("t2_words", acc_cnt, 12);
      chk("t2_pkt", pkt_count, 3);

      // Random ready and bursty FIFO fill, 100 words.
      target = acc_cnt + 100;
      pushed = 0;
      for (int c = 0; c < 3000 && acc_cnt < target; c++) begin
         if (pushed < 100 && $urandom_range(0, 2) == 0) begin
            k = $urandom_range(1, 4);
            if (k > 100 - pushed) k = 100 - pushed;
            push_words(k);
            pushed += k;
         end
         m_ready = $urandom_range(0, 1) != 0;
         cycle();
      end
      chk("t3_words", acc_cnt, target);
      chk("t3_pkt", pkt_count, target / PL);

      // Drop enable right after the first read with the stream stalled.
      m_ready = 1'b0;
      push_words(3);
      cycle();
      enable = 1'b0;
      cycle();
      chk("t4_drain_busy", busy, 1);
      m_ready = 1'b1;
      n_rdreq = 0;
      repeat (8) cycle();
      chk("t4_no_rdreq", n_rdreq, 0);
      chk("t4_idle_busy", busy, 0);
      chk("t4_words", acc_cnt, target + 2);

      // Reset mid-packet while a word is presented at beat 2.
      enable  = 1'b1;
      m_ready = 1'b1;
      push_words(8);
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         cycle();
         if (cap_cnt > acc_cnt && (acc_cnt % PL) == 2) found = 1'b1;
      end
      chk("t5_reach_beat2", found, 1);
      #2 aclr = 1'b1;
      #1;
      check_reset_outputs("t5_aclr");
      model_reset();
      @(posedge clk);
      #1 aclr = 1'b0;
      push_words(5);
      repeat (12) cycle();
      chk("t5_words", acc_cnt, 5);
      chk("t5_pkt", pkt_count, 1);
      chk("t5_pkt1", pkt_count1, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side drain controller placed directly downstream of the dual-clock 32-bit FIFO, running entirely in the FIFO read clock domain.
- Pops words from the FIFO's non-showahead read port using rdreq/q/rdempty, with q valid one cycle after rdreq.
- Buffers popped words in a 2-entry buffer and presents them on a valid/ready stream.
- Marks packet boundaries every PKT_LEN words and counts completed packets.

Parameters:
- DATA_W, 32, width of FIFO q and stream data.
- PKT_LEN, 4, words per packet (>=1); m_last asserted on the final word of each packet.
- CNT_W, 16, width of the completed-packet counter.

Ports:
- rdclk  in  1  FIFO read clock; the only clock of this block.
- aclr  in  1  asynchronous, active-high reset.
- enable  in  1  1 = drain the FIFO; 0 = stop issuing reads and flush what is already in flight.
- rdempty  in  1  FIFO read-side empty flag.
- rdreq  out  1  FIFO read request.
- q  in  DATA_W  FIFO read data; valid the cycle after rdreq=1.
- m_valid  out  1  stream word valid.
- m_ready  in  1  downstream accepts the word.
- m_data  out  DATA_W  stream word.
- m_last  out  1  current word is the last of its packet.
- pkt_count  out  CNT_W  number of packets completed (wraps).
- busy  out  1  state != IDLE.

Behaviour:
- Reset (aclr=1, asynchronous): rdreq=0, m_valid=0, m_data=0, m_last=0, pkt_count=0, busy=0, buffer empty, inflight=0, beat=0, state=IDLE.
- Internal signals:
  - occ: buffer occupancy, 0..2.
  - inflight: 1 if rdreq was asserted last cycle.
  - pop: m_valid & m_ready.
  - beat: word index within the packet, 0..PKT_LEN-1.
- Read issue: rdreq = (state==RUN) & ~rdempty & ((occ + inflight - pop) < 2).
  - This is combinational from m_ready and sized so sustained throughput is 1 word/cycle.
  - The buffer never overflows.
- Capture: when inflight=1, q is written into the buffer that cycle. A same-cycle push and pop is legal at any occupancy, including occ=2 with pop.
- Stream output:
  - m_valid = (occ != 0); m_data is the buffer head, in FIFO order.
  - m_data holds stable while m_valid & ~m_ready.
  - No bubble is inserted when the head is popped and a new word is written in the same cycle.
- Packet framing:
  - m_last = m_valid & (beat == PKT_LEN-1).
  - On pop: beat increments; when the popped word had m_last=1, beat returns to 0 and pkt_count increments, wrapping from 2^CNT_W-1 to 0.
  - PKT_LEN=1: every word is last.
- State machine:
  - IDLE: rdreq=0. Go to RUN when enable=1.
  - RUN: normal draining. Go to DRAIN when enable=0.
  - DRAIN:
    - rdreq=0.
    - Captures any in-flight word and keeps presenting buffered words.
    - Go to IDLE when occ==0 & inflight==0.
    - Returns to RUN if enable=1 reasserts first.
- Boundaries:
  - rdempty=1 in RUN: no rdreq; stream drains buffered words.
  - rdempty deasserting: first rdreq in the same cycle; m_valid two cycles later.
  - enable dropped mid-packet: beat is retained, so the next packet resumes its count after re-enable. There is no forced m_last.
  - m_ready=0 for a long stall: exactly 2 words are buffered, then rdreq=0 until a pop.
  - aclr mid-operation: everything returns to reset values immediately. Words popped from the FIFO but not yet streamed are discarded; this is acceptable because the FIFO is cleared by the same aclr.

Decomposition:
- Shared package fifo_rd_stream_pkg:
  - state enum {IDLE, RUN, DRAIN};
  - default DATA_W / PKT_LEN / CNT_W constants.
- One sub-module: stream_skid_buf, a 2-entry register buffer.
  - Inputs: push, push_data, pop.
  - Outputs: occ, head_data.
  - Simultaneous push/pop at any occupancy.
  - Same aclr and rdclk as the top.
- The top holds the FSM, read-issue logic, inflight flag, beat counter and pkt_count.

Test Plan:
- FIFO holds 0x1,0x2,0x3,0x4; enable=1; m_ready=1 -> rdreq for 4 consecutive cycles; m_valid for 4 consecutive cycles starting 2 cycles after the first rdreq; m_data 1,2,3,4; m_last only on 0x4; pkt_count goes to 1.
- FIFO holds 8 words; m_ready=0 for 10 cycles, then 1 -> exactly 2 rdreq pulses during the stall; m_data held at word0; all 8 words delivered in order with no loss or duplication; pkt_count=2.
- Random m_ready (50%) with 100 words streamed -> output sequence identical to input; pkt_count=25; occ never exceeds 2.
- enable dropped the cycle after an rdreq, with 1 word buffered -> state DRAIN; in-flight word captured; both words delivered; then IDLE with busy=0 and no further rdreq while rdempty=0.
- aclr pulsed while m_valid=1 with beat=2 -> all outputs 0 asynchronously; after release and re-enable, the next word has beat=0 and pkt_count restarts from 0.
- PKT_LEN=1, CNT_W=2, 5 words -> m_last on every word; pkt_count sequence 1,2,3,0,1.
